multi_port_sync_fifo: RTL and testbench
=======================================

Name: multi_port_sync_fifo

Overview:
Superscalar synchronous FIFO with up to PUSH_WIDTH enqueues and up to POP_WIDTH dequeues per cycle. Storage depth is arbitrary and need not be a power of 2. Exposes the POP_WIDTH oldest entries in parallel, plus occupancy and almost-full status. Intended for the fetch-to-decode instruction queue and other multi-issue buffers in the core.

Parameters:
DEPTH, 8, number of entries; any integer >= max(PUSH_WIDTH, POP_WIDTH), power of 2 not required
LINE_WIDTH, 32, bits per entry
PUSH_WIDTH, 2, max entries enqueued per cycle
POP_WIDTH, 2, max entries dequeued per cycle
AF_MARGIN, 2, almost_full asserts when free_count <= AF_MARGIN

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
flush  in  1  synchronous clear
push_num  in  $clog2(PUSH_WIDTH+1)  number of lanes to enqueue; lanes 0..push_num-1 are used
push_data  in  PUSH_WIDTH*LINE_WIDTH  lane i at bits [i*LINE_WIDTH +: LINE_WIDTH]; lane 0 is the oldest
pop_num  in  $clog2(POP_WIDTH+1)  number of entries to dequeue
head_data  out  POP_WIDTH*LINE_WIDTH  lane i = i-th oldest entry
head_valid  out  POP_WIDTH  bit i = (count > i)
count  out  $clog2(DEPTH+1)  occupied entries
free_count  out  $clog2(DEPTH+1)  DEPTH - count
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  free_count <= AF_MARGIN
push_reject  out  1  combinational; push_num > free_count and flush = 0
pop_underflow  out  1  combinational; pop_num > count and flush = 0

Behaviour:
- State: rp and wp, each in 0..DEPTH-1; count register; data array. The data array is not reset.
- Reset (rst = 0, asynchronous):
  - rp = wp = count = 0.
  - Outputs: empty = 1, full = 0, free_count = DEPTH, head_valid = 0, almost_full = (DEPTH <= AF_MARGIN).
  - Reset asserted mid-operation discards all contents immediately.
- Flush (rst = 1, flush = 1 at a clock edge):
  - rp, wp and count go to 0.
  - push and pop in the same cycle are ignored.
  - push_reject and pop_underflow are forced to 0.
- Push is all-or-nothing:
  - If push_num <= free_count (value at start of cycle), lanes 0..push_num-1 are written to wp, wp+1, ... (mod DEPTH) and wp advances by push_num.
  - Otherwise nothing is written, wp is unchanged and push_reject = 1.
  - Free space freed by a same-cycle pop is NOT usable.
- Pop is clipped:
  - popped = min(pop_num, count), with count taken at start of cycle.
  - rp advances by popped (mod DEPTH).
  - pop_underflow = 1 when clipping occurs.
  - An entry pushed in a cycle cannot be popped in that same cycle (no bypass).
- Occupancy update: count_next = count + pushed - popped, all in one cycle.
- Pointer wrap: ptr_next = ptr + n; if ptr_next >= DEPTH, subtract DEPTH. This must be correct for non-power-of-2 DEPTH.
- Read port, combinational from registered state:
  - head_data lane i = arr[(rp+i) mod DEPTH].
  - Lanes with head_valid[i] = 0 carry unspecified data; benches must not check them.
- Latency: an entry pushed at edge t appears on head_data/head_valid after edge t; a popped entry disappears after the edge.
- Status outputs are derived from registered count only; no combinational path from push_num/pop_num to them.
- Ordering: strict FIFO across lanes and cycles; lane 0 of a push is older than lane 1.
- Assertions (simulation only):
  - count <= DEPTH at all times.
  - (wp - rp) mod DEPTH == count mod DEPTH.

Test Plan:
- Reset/idle, DEPTH=6, P=2, Q=2: hold rst = 0, release -> empty = 1, count = 0, free_count = 6, head_valid = 2'b00; pop_num = 1 gives pop_underflow = 1 and state unchanged.
- Fill/wrap, DEPTH=6: push pairs (A,B), (C,D), (E,F) -> full = 1. Then push_num = 1 -> push_reject = 1, count stays 6. Pop 2 -> head shows C,D. Push (G,H) -> wp wraps to 2. Drain -> order is C,D,E,F,G,H.
- Simultaneous push and pop, count = 6: push_num = 2, pop_num = 2 -> push_reject = 1, only the pop happens, count = 4. Next cycle, same request -> both happen, count = 4, head advances by 2.
- Partial pop clipping: count = 1 (entry X), pop_num = 2 and push_num = 2 with (Y,Z) -> pop_underflow = 1, popped = 1, count = 2, head = Y,Z, head_valid = 2'b11.
- Flush priority: count = 4, flush = 1 with push_num = 2 and pop_num = 2 -> next cycle count = 0, empty = 1, push_reject = 0. Push (P,Q) in the following cycle -> head = P,Q.
- Async reset mid-stream: assert rst = 0 between edges with count = 3 -> empty = 1 and count = 0 without waiting for a clock edge. almost_full (AF_MARGIN = 2) checked at count 3 (0), 4 (1) and 6 (1).

Source files
------------

// File: rtl/multi_port_sync_fifo_if.sv
// Bundles the enqueue/dequeue request and status signals of multi_port_sync_fifo.
//   master : the client that drives flush/push/pop and observes head data and status
//   slave  : the FIFO itself
//   flush         - synchronous clear of all contents
//   push_num/data - lanes 0..push_num-1 enqueued, lane 0 oldest
//   pop_num       - entries to dequeue (clipped to occupancy)
//   head_data/valid - POP_WIDTH oldest entries and their validity
//   count/free_count/full/empty/almost_full - registered occupancy status
//   push_reject/pop_underflow - combinational request diagnostics
interface multi_port_sync_fifo_if #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned LINE_WIDTH = 32,
    parameter int unsigned PUSH_WIDTH = 2,
    parameter int unsigned POP_WIDTH  = 2
);
    localparam int unsigned PN_W  = $clog2(PUSH_WIDTH + 1);
    localparam int unsigned QN_W  = $clog2(POP_WIDTH + 1);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                             flush;
    logic [PN_W-1:0]                  push_num;
    logic [PUSH_WIDTH*LINE_WIDTH-1:0] push_data;
    logic [QN_W-1:0]                  pop_num;
    logic [POP_WIDTH*LINE_WIDTH-1:0]  head_data;
    logic [POP_WIDTH-1:0]             head_valid;
    logic [CNT_W-1:0]                 count;
    logic [CNT_W-1:0]                 free_count;
    logic                             full;
    logic                             empty;
    logic                             almost_full;
    logic                             push_reject;
    logic                             pop_underflow;

    modport master (
        output flush, push_num, push_data, pop_num,
        input  head_data, head_valid, count, free_count, full, empty,
               almost_full, push_reject, pop_underflow
    );

    modport slave (
        input  flush, push_num, push_data, pop_num,
        output head_data, head_valid, count, free_count, full, empty,
               almost_full, push_reject, pop_underflow
    );
endinterface

// File: rtl/multi_port_sync_fifo.sv
// Superscalar synchronous FIFO: up to PUSH_WIDTH enqueues and POP_WIDTH dequeues
// per cycle over a circular buffer of arbitrary (non power-of-2) DEPTH.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - multi_port_sync_fifo_if.slave (request, head read port, status)
// Pushes are all-or-nothing against the start-of-cycle free space; pops are
// clipped to the start-of-cycle occupancy. Flush wins over push and pop.
module multi_port_sync_fifo #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned LINE_WIDTH = 32,
    parameter int unsigned PUSH_WIDTH = 2,
    parameter int unsigned POP_WIDTH  = 2,
    parameter int unsigned AF_MARGIN  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    multi_port_sync_fifo_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough for ptr + n (< 2*DEPTH) and for any push_num/pop_num encoding.
    localparam int unsigned SUM_W = $clog2(2 * DEPTH + 1);

    logic [LINE_WIDTH-1:0] arr [DEPTH];

    logic [PTR_W-1:0]     rp_q, wp_q, rp_next, wp_next;
    logic [CNT_W-1:0]     count_q, free_q, count_next, free_next;
    logic                 full_q, empty_q, af_q;
    logic [POP_WIDTH-1:0] hv_q, hv_next;

    logic [SUM_W-1:0]     push_w, pop_w, cnt_w, free_w, pushed, popped;
    logic                 reject_c, underflow_c;
    logic [PTR_W-1:0]     wr_idx [PUSH_WIDTH];
    logic [PTR_W-1:0]     rd_idx [POP_WIDTH];

    // Circular pointer advance; single conditional subtract since n <= DEPTH.
    function automatic logic [PTR_W-1:0] adv(input logic [PTR_W-1:0] p,
                                             input logic [SUM_W-1:0] n);
        logic [SUM_W-1:0] s;
        s = SUM_W'(p) + n;
        if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
        return PTR_W'(s);
    endfunction

    // Request evaluation and next-state computation.
    always_comb begin
        push_w      = SUM_W'(bus.push_num);
        pop_w       = SUM_W'(bus.pop_num);
        cnt_w       = SUM_W'(count_q);
        free_w      = SUM_W'(free_q);
        pushed      = '0;
        popped      = '0;
        reject_c    = !bus.flush && (push_w > free_w);
        underflow_c = !bus.flush && (pop_w > cnt_w);

        if (!bus.flush) begin
            // Encodings above PUSH_WIDTH have no lanes behind them; clamp.
            if (!reject_c) pushed = (push_w > SUM_W'(PUSH_WIDTH)) ? SUM_W'(PUSH_WIDTH) : push_w;
            popped = underflow_c ? cnt_w : pop_w;
        end

        if (bus.flush) begin
            count_next = '0;
            wp_next    = '0;
            rp_next    = '0;
        end else begin
            count_next = CNT_W'(cnt_w + pushed - popped);
            wp_next    = adv(wp_q, pushed);
            rp_next    = adv(rp_q, popped);
        end

        free_next = CNT_W'(DEPTH) - count_next;
        for (int i = 0; i < POP_WIDTH; i++) begin
            hv_next[i] = (32'(count_next) > 32'(i));
        end
    end

    // Write and read slot indices per lane.
    always_comb begin
        for (int i = 0; i < PUSH_WIDTH; i++) wr_idx[i] = adv(wp_q, SUM_W'(i));
        for (int i = 0; i < POP_WIDTH; i++)  rd_idx[i] = adv(rp_q, SUM_W'(i));
    end

    // Pointer, occupancy and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rp_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
            free_q  <= CNT_W'(DEPTH);
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= (DEPTH <= AF_MARGIN);
            hv_q    <= '0;
        end else begin
            rp_q    <= rp_next;
            wp_q    <= wp_next;
            count_q <= count_next;
            free_q  <= free_next;
            full_q  <= (count_next == CNT_W'(DEPTH));
            empty_q <= (count_next == '0);
            af_q    <= (32'(free_next) <= AF_MARGIN);
            hv_q    <= hv_next;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            if (SUM_W'(i) < pushed) arr[wr_idx[i]] <= bus.push_data[i*LINE_WIDTH +: LINE_WIDTH];
        end
    end

    // Head read port straight from registered read pointer.
    always_comb begin
        for (int i = 0; i < POP_WIDTH; i++) begin
            bus.head_data[i*LINE_WIDTH +: LINE_WIDTH] = arr[rd_idx[i]];
        end
    end

    assign bus.head_valid    = hv_q;
    assign bus.count         = count_q;
    assign bus.free_count    = free_q;
    assign bus.full          = full_q;
    assign bus.empty         = empty_q;
    assign bus.almost_full   = af_q;
    assign bus.push_reject   = reject_c;
    assign bus.pop_underflow = underflow_c;

`ifndef SYNTHESIS
    // Occupancy bound and pointer/count consistency.
    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        32'(count_q) <= DEPTH);
    a_ptr_count: assert property (@(posedge clk) disable iff (!rst)
        ((int'(wp_q) + int'(DEPTH) - int'(rp_q)) % int'(DEPTH)) == (int'(count_q) % int'(DEPTH)));
`endif

endmodule

// File: tb/tb_multi_port_sync_fifo.sv
// Directed bench for multi_port_sync_fifo at DEPTH=6, two push and two pop lanes.
module tb_multi_port_sync_fifo;
    localparam int unsigned DEPTH = 6;
    localparam int unsigned LW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    multi_port_sync_fifo_if #(.DEPTH(DEPTH), .LINE_WIDTH(LW), .PUSH_WIDTH(2), .POP_WIDTH(2)) bus ();

    multi_port_sync_fifo #(
        .DEPTH(DEPTH), .LINE_WIDTH(LW), .PUSH_WIDTH(2), .POP_WIDTH(2), .AF_MARGIN(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic fl, input int pn, input int qn,
                       input logic [LW-1:0] d0, input logic [LW-1:0] d1);
        bus.flush     = fl;
        bus.push_num  = 2'(pn);
        bus.pop_num   = 2'(qn);
        bus.push_data = {d1, d0};
        #1;
    endtask

    function automatic logic [LW-1:0] lane(input int i);
        logic [2*LW-1:0] hd;
        hd = bus.head_data;
        return hd[i*LW +: LW];
    endfunction

    task automatic check_head2(input string tag, input logic [LW-1:0] a, input logic [LW-1:0] b);
        check({tag, "_h0"}, 64'(lane(0)), 64'(a));
        check({tag, "_h1"}, 64'(lane(1)), 64'(b));
    endtask

    initial begin
        req(1'b0, 0, 0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty_held", 64'(bus.empty), 64'd1);
        rst = 1'b1;
        #1;
        check("idle_empty", 64'(bus.empty), 64'd1);
        check("idle_count", 64'(bus.count), 64'd0);
        check("idle_free", 64'(bus.free_count), 64'd6);
        check("idle_hv", 64'(bus.head_valid), 64'd0);
        check("idle_full", 64'(bus.full), 64'd0);
        check("idle_af", 64'(bus.almost_full), 64'd0);

        req(1'b0, 0, 1, '0, '0);
        check("idle_underflow", 64'(bus.pop_underflow), 64'd1);
        check("idle_reject", 64'(bus.push_reject), 64'd0);
        step();
        check("idle_count_after_pop", 64'(bus.count), 64'd0);

        // Fill to six entries.
        req(1'b0, 2, 0, 32'hA, 32'hB);
        step();
        check("fill2_count", 64'(bus.count), 64'd2);
        check("fill2_af", 64'(bus.almost_full), 64'd0);
        check_head2("fill2", 32'hA, 32'hB);
        req(1'b0, 2, 0, 32'hC, 32'hD);
        step();
        check("fill4_af", 64'(bus.almost_full), 64'd1);
        req(1'b0, 2, 0, 32'hE, 32'hF);
        step();
        check("fill6_full", 64'(bus.full), 64'd1);
        check("fill6_count", 64'(bus.count), 64'd6);
        check("fill6_free", 64'(bus.free_count), 64'd0);
        check("fill6_af", 64'(bus.almost_full), 64'd1);

        req(1'b0, 1, 0, 32'h99, 32'h0);
        check("full_reject", 64'(bus.push_reject), 64'd1);
        step();
        check("full_reject_count", 64'(bus.count), 64'd6);

        req(1'b0, 0, 2, '0, '0);
        step();
        check("pop2_count", 64'(bus.count), 64'd4);
        check_head2("pop2", 32'hC, 32'hD);

        // Wrap the write pointer.
        req(1'b0, 2, 0, 32'h6, 32'h7);
        step();
        check("wrap_count", 64'(bus.count), 64'd6);
        check_head2("wrap", 32'hC, 32'hD);

        // Push blocked at full while the pop still proceeds.
        req(1'b0, 2, 2, 32'h11, 32'h12);
        check("sim_reject", 64'(bus.push_reject), 64'd1);
        step();
        check("sim_count", 64'(bus.count), 64'd4);
        check_head2("sim", 32'hE, 32'hF);
        req(1'b0, 2, 2, 32'h11, 32'h12);
        check("sim2_reject", 64'(bus.push_reject), 64'd0);
        step();
        check("sim2_count", 64'(bus.count), 64'd4);
        check_head2("sim2", 32'h6, 32'h7);

        req(1'b0, 0, 2, '0, '0);
        step();
        check_head2("drain1", 32'h11, 32'h12);
        step();
        check("drain_empty", 64'(bus.empty), 64'd1);
        check("drain_hv", 64'(bus.head_valid), 64'd0);

        // Pop clipping with concurrent push.
        req(1'b0, 1, 0, 32'h58, 32'h0);
        step();
        check("x_hv", 64'(bus.head_valid), 64'd1);
        check("x_h0", 64'(lane(0)), 64'h58);
        req(1'b0, 2, 2, 32'h59, 32'h5A);
        check("clip_underflow", 64'(bus.pop_underflow), 64'd1);
        check("clip_reject", 64'(bus.push_reject), 64'd0);
        step();
        check("clip_count", 64'(bus.count), 64'd2);
        check("clip_hv", 64'(bus.head_valid), 64'd3);
        check_head2("clip", 32'h59, 32'h5A);

        // Flush wins over push and pop.
        req(1'b0, 2, 0, 32'h20, 32'h21);
        step();
        check("preflush_count", 64'(bus.count), 64'd4);
        req(1'b1, 2, 3, 32'h30, 32'h31);
        check("flush_reject", 64'(bus.push_reject), 64'd0);
        check("flush_underflow", 64'(bus.pop_underflow), 64'd0);
        step();
        check("flush_count", 64'(bus.count), 64'd0);
        check("flush_empty", 64'(bus.empty), 64'd1);
        req(1'b0, 2, 0, 32'h50, 32'h51);
        step();
        check_head2("postflush", 32'h50, 32'h51);

        // Async reset between edges.
        req(1'b0, 1, 0, 32'h52, 32'h0);
        step();
        check("c3_count", 64'(bus.count), 64'd3);
        check("c3_af", 64'(bus.almost_full), 64'd0);
        req(1'b0, 0, 0, '0, '0);
        #1;
        rst = 1'b0;
        #1;
        check("arst_empty", 64'(bus.empty), 64'd1);
        check("arst_count", 64'(bus.count), 64'd0);
        check("arst_free", 64'(bus.free_count), 64'd6);
        check("arst_hv", 64'(bus.head_valid), 64'd0);
        step();
        rst = 1'b1;
        req(1'b0, 1, 0, 32'h77, 32'h0);
        step();
        check("post_arst_count", 64'(bus.count), 64'd1);
        check("post_arst_h0", 64'(lane(0)), 64'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
